// File: rtl/instruction_fetch_pkg.sv
// Shared types for the fetch stage: controller states, fault causes and the
// datapath width.
package roxxon_fetch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_BUS_ERR  = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fault_cause_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response channel; the fetch stage is the master.
interface instruction_fetch_if;
    import roxxon_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output imem_err
    );

endinterface

// File: rtl/instruction_fetch_timeout_counter.sv
// Saturating wait-cycle counter; expired flags the LIMIT-th enabled cycle
// since the last clear so the caller can act on that same cycle.
module fetch_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(LIMIT + 1);
    localparam logic [TW-1:0] SAT_VAL  = TW'(LIMIT);
    localparam logic [TW-1:0] LAST_VAL = TW'(LIMIT - 1);

    logic [TW-1:0] count_r;

    // count enabled cycles, holding at LIMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != SAT_VAL)) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r >= LAST_VAL);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: requests the word at PC_out, holds it for decode and stalls
// the PC so it advances exactly once per delivered instruction.
module instruction_fetch
    import roxxon_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     PC_out,
    output logic                pc_stall,
    input  logic                flush,
    instruction_fetch_if.master imem,
    output logic [XLEN-1:0]     instr,
    output logic [XLEN-1:0]     instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic                fetch_fault,
    output fault_cause_t        fault_cause
);

    fetch_state_t    state_r, state_next;
    fault_cause_t    cause_r, cause_next;
    logic [XLEN-1:0] instr_r, instr_pc_r;
    logic            aligned_s, req_s, valid_s;
    logic            load_instr_s, load_pc_s;
    logic            timer_clear_s, timer_en_s, timer_expired_s;

    assign aligned_s  = is_word_aligned(PC_out[1:0]);
    assign timer_en_s = (state_r == ST_WAIT) || (state_r == ST_DRAIN);

    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
    );

    // controller state and fault cause
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cause_r <= FC_NONE;
        end else begin
            state_r <= state_next;
            cause_r <= cause_next;
        end
    end

    // next state and per-cycle strobes; flush outranks everything it meets
    always_comb begin
        state_next    = state_r;
        cause_next    = cause_r;
        req_s         = 1'b0;
        valid_s       = 1'b0;
        load_instr_s  = 1'b0;
        load_pc_s     = 1'b0;
        timer_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                req_s = !flush && aligned_s;
                if (flush) begin
                    state_next = ST_REQ;
                end else if (!aligned_s) begin
                    state_next = ST_FAULT;
                    cause_next = FC_MISALIGN;
                end else if (imem.imem_gnt) begin
                    state_next    = ST_WAIT;
                    load_pc_s     = 1'b1;
                    timer_clear_s = 1'b1;
                end else begin
                    state_next = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_next = imem.imem_rvalid ? ST_REQ : ST_DRAIN;
                end else if (imem.imem_rvalid) begin
                    if (imem.imem_err) begin
                        state_next = ST_FAULT;
                        cause_next = FC_BUS_ERR;
                    end else begin
                        state_next   = ST_HOLD;
                        load_instr_s = 1'b1;
                    end
                end else if (timer_expired_s) begin
                    state_next = ST_FAULT;
                    cause_next = FC_TIMEOUT;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (imem.imem_rvalid || timer_expired_s) begin
                    state_next = ST_REQ;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                valid_s = !flush;
                if (flush || instr_ready) begin
                    state_next = ST_REQ;
                end else begin
                    state_next = ST_HOLD;
                end
            end
            ST_FAULT: begin
                if (flush) begin
                    state_next = ST_REQ;
                    cause_next = FC_NONE;
                end else begin
                    state_next = ST_FAULT;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cause_next = FC_NONE;
            end
        endcase
    end

    // address captured at grant, word captured at good response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r    <= '0;
            instr_pc_r <= '0;
        end else begin
            if (load_pc_s) begin
                instr_pc_r <= PC_out;
            end
            if (load_instr_s) begin
                instr_r <= imem.imem_rdata;
            end
        end
    end

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = (state_r == ST_REQ) ? PC_out : '0;
    assign instr_valid    = valid_s;
    assign pc_stall       = !(flush || (valid_s && instr_ready));
    assign fetch_fault    = (state_r == ST_FAULT);
    assign fault_cause    = cause_r;
    assign instr          = instr_r;
    assign instr_pc       = instr_pc_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_instruction_fetch;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_reg;
    logic        pc_stall, flush, instr_valid, instr_ready, fetch_fault;
    logic [31:0] instr, instr_pc;
    logic [1:0]  fault_cause;

    instruction_fetch_if imem_bus ();

    instruction_fetch #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .PC_out      (pc_reg),
        .pc_stall    (pc_stall),
        .flush       (flush),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // model: what the fetch stage owes the pipeline
    bit          m_idle, m_out, m_disc, m_held;
    int          m_cause, m_wait;
    logic [31:0] m_instr, m_ipc;

    bit          gnt_given, rv_given;
    logic [31:0] s_req, s_addr, s_valid, s_instr, s_ipc, s_stall, s_fault, s_cause;

    bit mem_pending;
    int mem_delay;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_out = 1'b0; m_disc = 1'b0; m_held = 1'b0;
        m_cause = 0; m_wait = 0; mem_pending = 1'b0; mem_delay = 0;
    endtask

    task automatic cycle(input bit f, input logic [31:0] tgt, input bit rdy,
                         input bit g, input bit rv, input logic [31:0] rd, input bit e);
        bit          issuing, e_req, e_valid, e_stall;
        logic [31:0] e_addr;
        issuing = !m_idle && !m_out && !m_held && (m_cause == 0);
        e_req   = issuing && !f && (pc_reg[1:0] == 2'b00);
        e_addr  = issuing ? pc_reg : 32'h0;
        e_valid = m_held && !f;
        e_stall = !(f || (e_valid && rdy));
        gnt_given = g && e_req;
        rv_given  = rv;
        flush = f; instr_ready = rdy;
        imem_bus.imem_gnt = gnt_given; imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata = rd; imem_bus.imem_err = e;
        @(negedge clk);
        s_req = 32'(imem_bus.imem_req); s_addr = imem_bus.imem_addr;
        s_valid = 32'(instr_valid); s_instr = instr; s_ipc = instr_pc;
        s_stall = 32'(pc_stall); s_fault = 32'(fetch_fault); s_cause = 32'(fault_cause);
        chk("pc_stall", s_stall, 32'(e_stall));
        chk("imem_req", s_req, 32'(e_req));
        chk("imem_addr", s_addr, e_addr);
        chk("instr_valid", s_valid, 32'(e_valid));
        chk("fetch_fault", s_fault, 32'(m_cause != 0));
        chk("fault_cause", s_cause, 32'(m_cause));
        if (e_valid) begin
            chk("instr", s_instr, m_instr);
            chk("instr_pc", s_ipc, m_ipc);
        end
        @(posedge clk);
        #1;
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (issuing) begin
            if (!f) begin
                if (pc_reg[1:0] != 2'b00) m_cause = 1;
                else if (gnt_given) begin
                    m_out = 1'b1; m_disc = 1'b0; m_wait = 0; m_ipc = pc_reg;
                end
            end
        end else if (m_out) begin
            m_wait++;
            if (m_disc) begin
                if (rv || m_wait >= TMO) m_out = 1'b0;
            end else if (f) begin
                if (rv) m_out = 1'b0; else m_disc = 1'b1;
            end else if (rv) begin
                m_out = 1'b0;
                if (e) m_cause = 2;
                else begin m_held = 1'b1; m_instr = rd; end
            end else if (m_wait >= TMO) begin
                m_out = 1'b0; m_cause = 3;
            end
        end else if (m_held) begin
            if (f || rdy) m_held = 1'b0;
        end else begin
            if (f) m_cause = 0;
        end
        if (f) pc_reg = tgt;
        else if (!e_stall) pc_reg = pc_reg + 32'd4;
    endtask

    initial begin
        reset = 1'b1; pc_reg = 32'h0; flush = 1'b0; instr_ready = 1'b0;
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = 32'h0; imem_bus.imem_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_stall", 32'(pc_stall), 32'd1);
        chk("rst_imem_req", 32'(imem_bus.imem_req), 32'd0);
        chk("rst_imem_addr", imem_bus.imem_addr, 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        chk("rst_fault_cause", 32'(fault_cause), 32'd0);
        chk("rst_instr", instr, 32'd0);
        reset = 1'b0;

        // best case fetch of 0x00500093 at PC 0
        cycle(0, 32'h0, 1, 0, 0, 32'h0, 0);
        chk("t1_idle_stall", s_stall, 32'd1);
        cycle(0, 32'h0, 1, 1, 0, 32'h0, 0);
        chk("t1_req", s_req, 32'd1);
        chk("t1_addr", s_addr, 32'h0);
        chk("t1_req_stall", s_stall, 32'd1);
        cycle(0, 32'h0, 1, 0, 1, 32'h00500093, 0);
        chk("t1_wait_valid", s_valid, 32'd0);
        chk("t1_wait_stall", s_stall, 32'd1);
        cycle(0, 32'h0, 1, 0, 0, 32'h0, 0);
        chk("t1_valid", s_valid, 32'd1);
        chk("t1_instr", s_instr, 32'h00500093);
        chk("t1_instr_pc", s_ipc, 32'h0);
        chk("t1_hold_stall", s_stall, 32'd0);
        chk("t1_pc_adv", pc_reg, 32'h4);

        // misaligned PC, then recovery by flush to 0x8
        cycle(1, 32'h6, 0, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        chk("t2_misalign_req", s_req, 32'd0);
        cycle(0, 32'h0, 0, 0, 0, 32'h0, 0);
        chk("t2_fault", s_fault, 32'd1);
        chk("t2_cause", s_cause, 32'd1);
        chk("t2_fault_req", s_req, 32'd0);
        cycle(1, 32'h8, 0, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        chk("t2_redir_addr", s_addr, 32'h8);
        chk("t2_redir_req", s_req, 32'd1);
        chk("t2_redir_cause", s_cause, 32'd0);

        // no response for 16 wait cycles -> timeout
        for (int i = 0; i < TMO; i++) cycle(0, 32'h0, 0, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 0, 0, 32'h0, 0);
        chk("t3_timeout_cause", s_cause, 32'd3);
        chk("t3_timeout_fault", s_fault, 32'd1);
        cycle(1, 32'h10, 0, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        cycle(0, 32'h0, 0, 0, 1, 32'hCAFE0000, 1);
        cycle(0, 32'h0, 0, 0, 0, 32'h0, 0);
        chk("t3_buserr_cause", s_cause, 32'd2);
        cycle(1, 32'h20, 0, 0, 0, 32'h0, 0);

        // flush while waiting: late word is discarded
        cycle(0, 32'h0, 1, 1, 0, 32'h0, 0);
        cycle(1, 32'h40, 1, 0, 0, 32'h0, 0);
        chk("t4_flush_valid", s_valid, 32'd0);
        cycle(0, 32'h0, 1, 0, 0, 32'h0, 0);
        chk("t4_drain_req", s_req, 32'd0);
        cycle(0, 32'h0, 1, 0, 0, 32'h0, 0);
        cycle(0, 32'h0, 1, 0, 1, 32'hDEADBEEF, 0);
        chk("t4_drain_valid", s_valid, 32'd0);
        cycle(0, 32'h0, 0, 1, 0, 32'h0, 0);
        chk("t4_req_after", s_req, 32'd1);
        chk("t4_addr_after", s_addr, 32'h40);

        // decode back-pressure for 5 cycles, then reset mid-hold
        cycle(0, 32'h0, 0, 0, 1, 32'h12345678, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 32'h0, 0, 0, 0, 32'h0, 0);
            chk("t5_hold_valid", s_valid, 32'd1);
            chk("t5_hold_instr", s_instr, 32'h12345678);
            chk("t5_hold_pc", s_ipc, 32'h40);
            chk("t5_hold_stall", s_stall, 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(instr_valid), 32'd0);
        chk("t5_rst_req", 32'(imem_bus.imem_req), 32'd0);
        chk("t5_rst_stall", 32'(pc_stall), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // randomized traffic with a latency-varying memory
        for (int n = 0; n < 3000; n++) begin
            bit          f, rdy, g, rv, e;
            logic [31:0] tgt;
            f   = ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            rdy = ($urandom_range(0, 9) < 7);
            g   = ($urandom_range(0, 2) != 0);
            e   = ($urandom_range(0, 9) == 0);
            rv  = mem_pending && (mem_delay == 0);
            if (!mem_pending && !g && ($urandom_range(0, 19) == 0)) rv = 1'b1;
            cycle(f, tgt, rdy, g, rv, $urandom, e);
            if (gnt_given) begin
                mem_pending = 1'b1;
                mem_delay = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
            end else if (mem_pending) begin
                if (rv_given) mem_pending = 1'b0;
                else if (mem_delay > 0) mem_delay--;
            end
            if (!m_out) mem_pending = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
